// File: rtl/axi2mem_pkg.sv
// Shared encodings for the AXI-to-memory responder: burst types, response codes
// and the state set of the single serializing FSM.
package axi2mem_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_RD_RESP,
      ST_WR_DATA,
      ST_WR_WAIT,
      ST_WR_RESP
   } state_e;

endpackage

// File: rtl/axi2mem_addr_gen.sv
// Next-beat address for an AXI burst. FIXED holds the address; INCR and WRAP
// both step by the beat size, wrapping silently at the top of the address space.
module axi2mem_addr_gen
   import axi2mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [2:0]            size,
   input  logic [1:0]            burst,
   output logic [ADDR_WIDTH-1:0] next_addr
);

   logic [ADDR_WIDTH-1:0] inc;

   always_comb begin
      inc = ADDR_WIDTH'(1) << size;
      if (burst == BURST_FIXED) begin
         next_addr = addr;
      end else begin
         next_addr = addr + inc;
      end
   end

endmodule

// File: rtl/axi2mem_slave.sv
// AXI4 responder that serializes read and write bursts into single-beat
// req/gnt/rvalid memory transactions, one outstanding request at a time.
module axi2mem_slave
   import axi2mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [ID_WIDTH-1:0]     aw_id_i,
   input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
   input  logic [7:0]              aw_len_i,
   input  logic [2:0]              aw_size_i,
   input  logic [1:0]              aw_burst_i,
   input  logic                    aw_valid_i,
   output logic                    aw_ready_o,
   input  logic [DATA_WIDTH-1:0]   w_data_i,
   input  logic [DATA_WIDTH/8-1:0] w_strb_i,
   input  logic                    w_last_i,
   input  logic                    w_valid_i,
   output logic                    w_ready_o,
   output logic [ID_WIDTH-1:0]     b_id_o,
   output logic [1:0]              b_resp_o,
   output logic                    b_valid_o,
   input  logic                    b_ready_i,
   input  logic [ID_WIDTH-1:0]     ar_id_i,
   input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
   input  logic [7:0]              ar_len_i,
   input  logic [2:0]              ar_size_i,
   input  logic [1:0]              ar_burst_i,
   input  logic                    ar_valid_i,
   output logic                    ar_ready_o,
   output logic [ID_WIDTH-1:0]     r_id_o,
   output logic [DATA_WIDTH-1:0]   r_data_o,
   output logic [1:0]              r_resp_o,
   output logic                    r_last_o,
   output logic                    r_valid_o,
   input  logic                    r_ready_i,
   output logic                    mem_req_o,
   input  logic                    mem_gnt_i,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic                    mem_we_o,
   output logic [DATA_WIDTH/8-1:0] mem_be_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic                    mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
   input  logic                    mem_err_i
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   state_e                  state_reg, state_next;
   logic [ID_WIDTH-1:0]     id_reg, id_next;
   logic [ADDR_WIDTH-1:0]   addr_reg, addr_next, addr_inc;
   logic [7:0]              len_reg, len_next;
   logic [7:0]              cnt_reg, cnt_next;
   logic [2:0]              size_reg, size_next;
   logic [1:0]              burst_reg, burst_next;
   logic                    err_reg, err_next;
   logic                    prio_write_reg, prio_write_next;
   logic [DATA_WIDTH-1:0]   r_data_reg, r_data_next;
   logic [1:0]              r_resp_reg, r_resp_next;

   // Burst termination is taken from the latched length alone.
   logic unused_w_last;
   assign unused_w_last = w_last_i;

   axi2mem_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_gen (
      .addr      (addr_reg),
      .size      (size_reg),
      .burst     (burst_reg),
      .next_addr (addr_inc)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg      <= ST_IDLE;
         id_reg         <= '0;
         addr_reg       <= '0;
         len_reg        <= '0;
         cnt_reg        <= '0;
         size_reg       <= '0;
         burst_reg      <= '0;
         err_reg        <= 1'b0;
         prio_write_reg <= 1'b0;
         r_data_reg     <= '0;
         r_resp_reg     <= RESP_OKAY;
      end else begin
         state_reg      <= state_next;
         id_reg         <= id_next;
         addr_reg       <= addr_next;
         len_reg        <= len_next;
         cnt_reg        <= cnt_next;
         size_reg       <= size_next;
         burst_reg      <= burst_next;
         err_reg        <= err_next;
         prio_write_reg <= prio_write_next;
         r_data_reg     <= r_data_next;
         r_resp_reg     <= r_resp_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      id_next         = id_reg;
      addr_next       = addr_reg;
      len_next        = len_reg;
      cnt_next        = cnt_reg;
      size_next       = size_reg;
      burst_next      = burst_reg;
      err_next        = err_reg;
      prio_write_next = prio_write_reg;
      r_data_next     = r_data_reg;
      r_resp_next     = r_resp_reg;

      ar_ready_o  = 1'b0;
      aw_ready_o  = 1'b0;
      w_ready_o   = 1'b0;
      b_valid_o   = 1'b0;
      b_resp_o    = RESP_OKAY;
      r_valid_o   = 1'b0;
      r_last_o    = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_wdata_o = '0;

      case (state_reg)
         ST_IDLE: begin
            // Alternating priority only matters when both channels collide.
            ar_ready_o = ar_valid_i && !(aw_valid_i && prio_write_reg);
            aw_ready_o = aw_valid_i && !(ar_valid_i && !prio_write_reg);
            if (ar_ready_o) begin
               id_next    = ar_id_i;
               addr_next  = ar_addr_i;
               len_next   = ar_len_i;
               size_next  = ar_size_i;
               burst_next = ar_burst_i;
               cnt_next   = '0;
               state_next = ST_RD_REQ;
            end else if (aw_ready_o) begin
               id_next    = aw_id_i;
               addr_next  = aw_addr_i;
               len_next   = aw_len_i;
               size_next  = aw_size_i;
               burst_next = aw_burst_i;
               cnt_next   = '0;
               err_next   = 1'b0;
               state_next = ST_WR_DATA;
            end
         end

         ST_RD_REQ: begin
            mem_req_o = 1'b1;
            if (mem_gnt_i) begin
               state_next = ST_RD_WAIT;
            end
         end

         ST_RD_WAIT: begin
            if (mem_rvalid_i) begin
               r_data_next = mem_rdata_i;
               r_resp_next = mem_err_i ? RESP_SLVERR : RESP_OKAY;
               state_next  = ST_RD_RESP;
            end
         end

         ST_RD_RESP: begin
            r_valid_o = 1'b1;
            r_last_o  = (cnt_reg == len_reg);
            if (r_ready_i) begin
               if (cnt_reg == len_reg) begin
                  prio_write_next = 1'b1;
                  state_next      = ST_IDLE;
               end else begin
                  addr_next  = addr_inc;
                  cnt_next   = cnt_reg + 8'd1;
                  state_next = ST_RD_REQ;
               end
            end
         end

         ST_WR_DATA: begin
            // W acceptance is the memory grant itself, so no data is buffered.
            mem_req_o   = w_valid_i;
            mem_we_o    = 1'b1;
            mem_wdata_o = w_data_i;
            mem_be_o    = STRB_WIDTH'(w_strb_i);
            w_ready_o   = mem_gnt_i;
            if (w_valid_i && mem_gnt_i) begin
               state_next = ST_WR_WAIT;
            end
         end

         ST_WR_WAIT: begin
            if (mem_rvalid_i) begin
               err_next = err_reg | mem_err_i;
               if (cnt_reg == len_reg) begin
                  state_next = ST_WR_RESP;
               end else begin
                  addr_next  = addr_inc;
                  cnt_next   = cnt_reg + 8'd1;
                  state_next = ST_WR_DATA;
               end
            end
         end

         ST_WR_RESP: begin
            b_valid_o = 1'b1;
            b_resp_o  = err_reg ? RESP_SLVERR : RESP_OKAY;
            if (b_ready_i) begin
               prio_write_next = 1'b0;
               state_next      = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign mem_addr_o = addr_reg;
   assign r_data_o   = r_data_reg;
   assign r_resp_o   = r_resp_reg;
   assign r_id_o     = id_reg;
   assign b_id_o     = id_reg;

endmodule

// File: tb/tb_axi2mem_slave.sv
// Randomized scoreboard bench for axi2mem_slave: a transaction-level reference
// predicts memory requests and R/B beats, independent monitors pop and compare.
module tb_axi2mem_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] aw_id_i, ar_id_i, b_id_o, r_id_o;
   logic [31:0] aw_addr_i, ar_addr_i;
   logic [7:0]  aw_len_i, ar_len_i;
   logic [2:0]  aw_size_i, ar_size_i;
   logic [1:0]  aw_burst_i, ar_burst_i;
   logic        aw_valid_i, aw_ready_o, ar_valid_i, ar_ready_o;
   logic [31:0] w_data_i;
   logic [3:0]  w_strb_i;
   logic        w_last_i, w_valid_i, w_ready_o;
   logic [1:0]  b_resp_o, r_resp_o;
   logic        b_valid_o, b_ready_i;
   logic [31:0] r_data_o;
   logic        r_last_o, r_valid_o, r_ready_i;
   logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, mem_err_i;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic [3:0]  mem_be_o;

   always #5 clk = ~clk;

   axi2mem_slave dut (
      .clk_i(clk), .rst_i(rst),
      .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i), .aw_size_i(aw_size_i),
      .aw_burst_i(aw_burst_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
      .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_last_i(w_last_i), .w_valid_i(w_valid_i),
      .w_ready_o(w_ready_o), .b_id_o(b_id_o), .b_resp_o(b_resp_o), .b_valid_o(b_valid_o),
      .b_ready_i(b_ready_i), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i),
      .ar_size_i(ar_size_i), .ar_burst_i(ar_burst_i), .ar_valid_i(ar_valid_i),
      .ar_ready_o(ar_ready_o), .r_id_o(r_id_o), .r_data_o(r_data_o), .r_resp_o(r_resp_o),
      .r_last_o(r_last_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
      .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
   );

   typedef struct {
      logic [15:0] id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [15:0] errm;
   } txn_t;
   typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; logic err; } mem_exp_t;
   typedef struct { logic [15:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;
   typedef struct { logic [15:0] id; logic [1:0] resp; } b_exp_t;
   typedef struct { logic [31:0] data; logic [3:0] strb; } w_beat_t;

   mem_exp_t exp_mem[$];
   r_exp_t   exp_r[$];
   b_exp_t   exp_b[$];
   w_beat_t  w_q[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int mem_mode = 1;      // 0 random, 1 immediate, 2 grant now / answer 6 cycles later
   int rready_mode = 1;   // 0 random, 1 always, 2 hold low 5 cycles per beat
   bit bready_rand = 1'b0;
   bit model_prio = 1'b0;
   int rise_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      checks++;
      failures++;
      $display("FAIL %s actual=%s required=none (cycle %0d)", name, what, cyc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] beat_addr(input txn_t t, input int k);
      if (t.burst == 2'b00) return t.addr;
      return t.addr + 32'(k) * (32'd1 << t.size);
   endfunction

   function automatic logic [31:0] rd_func(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'hDEADBEEF;
      return {a[15:0], ~a[31:16]} ^ 32'h3C5A_96E1;
   endfunction

   function automatic txn_t rand_txn();
      txn_t t;
      t.id    = 16'($urandom);
      t.addr  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : 32'($urandom);
      t.len   = 8'($urandom_range(0, 7));
      t.size  = 3'($urandom_range(0, 2));
      t.burst = 2'($urandom_range(0, 2));
      t.errm  = 16'($urandom & $urandom & $urandom);
      return t;
   endfunction

   task automatic issue_read(input txn_t t);
      logic [31:0] a;
      for (int k = 0; k <= int'(t.len); k++) begin
         a = beat_addr(t, k);
         exp_mem.push_back('{addr: a, we: 1'b0, be: 4'h0, wdata: 32'h0, err: t.errm[k]});
         exp_r.push_back('{id: t.id, data: rd_func(a), resp: t.errm[k] ? 2'b10 : 2'b00,
                           last: (k == int'(t.len))});
      end
      model_prio = 1'b1;
   endtask

   task automatic push_write(input txn_t t, input bit full_strb);
      logic [31:0] d;
      logic [3:0]  s;
      logic        any_err;
      any_err = 1'b0;
      for (int k = 0; k <= int'(t.len); k++) begin
         d = 32'($urandom);
         s = full_strb ? 4'hF : 4'($urandom);
         w_q.push_back('{data: d, strb: s});
         exp_mem.push_back('{addr: beat_addr(t, k), we: 1'b1, be: s, wdata: d, err: t.errm[k]});
         any_err = any_err | t.errm[k];
      end
      exp_b.push_back('{id: t.id, resp: any_err ? 2'b10 : 2'b00});
      model_prio = 1'b0;
   endtask

   task automatic send_ar(input txn_t t, output int hs);
      hs = -1;
      ar_id_i = t.id; ar_addr_i = t.addr; ar_len_i = t.len;
      ar_size_i = t.size; ar_burst_i = t.burst; ar_valid_i = 1'b1;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (ar_ready_o) begin
            hs = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      step();
      ar_valid_i = 1'b0;
      if (hs < 0) fail_now("ar_handshake", "timeout");
   endtask

   task automatic send_aw(input txn_t t, output int hs);
      hs = -1;
      aw_id_i = t.id; aw_addr_i = t.addr; aw_len_i = t.len;
      aw_size_i = t.size; aw_burst_i = t.burst; aw_valid_i = 1'b1;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (aw_ready_o) begin
            hs = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      step();
      aw_valid_i = 1'b0;
      if (hs < 0) fail_now("aw_handshake", "timeout");
   endtask

   task automatic collide(input txn_t tr, input txn_t tw);
      int  hs_a, hs_w;
      bit  write_first;
      write_first = model_prio;
      if (write_first) begin
         push_write(tw, 1'b0);
         issue_read(tr);
      end else begin
         issue_read(tr);
         push_write(tw, 1'b0);
      end
      fork
         send_ar(tr, hs_a);
         send_aw(tw, hs_w);
      join
      check("arb_write_first", 64'(hs_w < hs_a), 64'(write_first));
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((exp_mem.size() != 0 || exp_r.size() != 0 || exp_b.size() != 0 || w_q.size() != 0)
             && n < 3000) begin
         step();
         n++;
      end
      if (n >= 3000) begin
         fail_now("drain", "timeout");
         exp_mem.delete(); exp_r.delete(); exp_b.delete(); w_q.delete();
      end
      step();
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      model_prio = 1'b0;
   endtask

   // Memory responder: checks each granted request against the predicted queue.
   initial begin : mem_model
      mem_exp_t e;
      bit       granted, pending, p_we, p_err;
      int       delay;
      logic [31:0] p_addr;
      granted = 0; pending = 0; p_we = 0; p_err = 0; delay = 0; p_addr = '0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
      forever begin
         @(negedge clk);
         granted = 0;
         if (!rst && mem_req_o && mem_gnt_i) begin
            if (exp_mem.size() == 0) begin
               fail_now("mem_req", "unexpected request");
            end else begin
               e = exp_mem.pop_front();
               check("mem_addr", 64'(mem_addr_o), 64'(e.addr));
               check("mem_we", 64'(mem_we_o), 64'(e.we));
               if (e.we) begin
                  check("mem_be", 64'(mem_be_o), 64'(e.be));
                  check("mem_wdata", 64'(mem_wdata_o), 64'(e.wdata));
               end
               granted = 1; p_we = e.we; p_err = e.err; p_addr = e.addr;
            end
         end
         @(posedge clk); #1;
         mem_rvalid_i = 1'b0;
         mem_err_i    = 1'b0;
         mem_rdata_i  = 32'($urandom);
         if (granted) begin
            pending = 1;
            delay = (mem_mode == 1) ? 1 : (mem_mode == 2) ? 6 : $urandom_range(1, 3);
         end
         if (pending) begin
            if (delay <= 1) begin
               mem_rvalid_i = 1'b1;
               mem_err_i    = p_err;
               mem_rdata_i  = p_we ? 32'($urandom) : rd_func(p_addr);
               pending = 0;
            end else begin
               delay--;
            end
         end
         mem_gnt_i = (mem_mode != 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
   end

   // Write-data source: presents queued beats, drops one on each W handshake.
   initial begin : w_driver
      w_valid_i = 1'b0; w_data_i = '0; w_strb_i = '0; w_last_i = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && w_valid_i && w_ready_o && w_q.size() != 0) void'(w_q.pop_front());
         @(posedge clk); #1;
         if (w_q.size() != 0 && (mem_mode != 0 || $urandom_range(0, 3) != 0)) begin
            w_valid_i = 1'b1;
            w_data_i  = w_q[0].data;
            w_strb_i  = w_q[0].strb;
            w_last_i  = 1'($urandom_range(0, 1));
         end else begin
            w_valid_i = 1'b0;
         end
      end
   end

   // R monitor: compares accepted beats and holds beats stable under backpressure.
   initial begin : r_monitor
      r_exp_t e, prev;
      bit     have_prev, rv_prev;
      int     stall;
      have_prev = 0; rv_prev = 0; stall = 0;
      prev = '{id: '0, data: '0, resp: '0, last: 1'b0};
      r_ready_i = 1'b0;
      forever begin
         @(negedge clk);
         if (r_valid_o && !rv_prev) rise_cyc = cyc;
         rv_prev = r_valid_o;
         if (!rst && r_valid_o) begin
            check("r_no_mem_req", 64'(mem_req_o), 64'(0));
            if (have_prev) begin
               check("r_hold_data", 64'(r_data_o), 64'(prev.data));
               check("r_hold_resp", 64'(r_resp_o), 64'(prev.resp));
               check("r_hold_last", 64'(r_last_o), 64'(prev.last));
            end
            if (r_ready_i) begin
               if (exp_r.size() == 0) begin
                  fail_now("r_beat", "unexpected beat");
               end else begin
                  e = exp_r.pop_front();
                  check("r_id", 64'(r_id_o), 64'(e.id));
                  check("r_data", 64'(r_data_o), 64'(e.data));
                  check("r_resp", 64'(r_resp_o), 64'(e.resp));
                  check("r_last", 64'(r_last_o), 64'(e.last));
               end
               have_prev = 0;
               stall = 0;
            end else begin
               prev = '{id: r_id_o, data: r_data_o, resp: r_resp_o, last: r_last_o};
               have_prev = 1;
               stall++;
            end
         end else begin
            have_prev = 0;
         end
         @(posedge clk); #1;
         case (rready_mode)
            0:       r_ready_i = 1'($urandom_range(0, 1));
            2:       r_ready_i = (stall >= 5);
            default: r_ready_i = 1'b1;
         endcase
      end
   end

   initial begin : b_monitor
      b_exp_t e;
      b_ready_i = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && b_valid_o && b_ready_i) begin
            if (exp_b.size() == 0) begin
               fail_now("b_beat", "unexpected response");
            end else begin
               e = exp_b.pop_front();
               check("b_id", 64'(b_id_o), 64'(e.id));
               check("b_resp", 64'(b_resp_o), 64'(e.resp));
            end
         end
         @(posedge clk); #1;
         b_ready_i = bready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      txn_t t, t2;
      int   hs;
      rst = 1'b1;
      ar_valid_i = 1'b0; ar_id_i = '0; ar_addr_i = '0; ar_len_i = '0; ar_size_i = '0; ar_burst_i = '0;
      aw_valid_i = 1'b0; aw_id_i = '0; aw_addr_i = '0; aw_len_i = '0; aw_size_i = '0; aw_burst_i = '0;
      repeat (3) step();
      @(negedge clk);
      check("rst_ar_ready", 64'(ar_ready_o), 64'(0));
      check("rst_aw_ready", 64'(aw_ready_o), 64'(0));
      check("rst_w_ready", 64'(w_ready_o), 64'(0));
      check("rst_r_valid", 64'(r_valid_o), 64'(0));
      check("rst_b_valid", 64'(b_valid_o), 64'(0));
      check("rst_mem_req", 64'(mem_req_o), 64'(0));
      check("rst_mem_we", 64'(mem_we_o), 64'(0));
      check("rst_r_last", 64'(r_last_o), 64'(0));
      check("rst_resps", 64'({b_resp_o, r_resp_o}), 64'(0));
      check("rst_r_data", 64'(r_data_o), 64'(0));
      check("rst_ids", 64'({r_id_o, b_id_o}), 64'(0));
      check("rst_mem_addr", 64'(mem_addr_o), 64'(0));
      step();
      rst = 1'b0;

      // single read, immediate memory: R valid three cycles after AR
      t = '{id: 16'h0011, addr: 32'h100, len: 8'd0, size: 3'd2, burst: 2'b01, errm: 16'h0};
      issue_read(t);
      send_ar(t, hs);
      wait_done();
      check("rd_latency", 64'(rise_cyc - hs), 64'(3));

      // INCR write burst
      t = '{id: 16'h0022, addr: 32'h200, len: 8'd3, size: 3'd2, burst: 2'b01, errm: 16'h0};
      push_write(t, 1'b1);
      send_aw(t, hs);
      wait_done();

      // FIXED read under R backpressure
      rready_mode = 2;
      t = '{id: 16'h0033, addr: 32'h300, len: 8'd1, size: 3'd2, burst: 2'b00, errm: 16'h0};
      issue_read(t);
      send_ar(t, hs);
      wait_done();
      rready_mode = 1;

      // error reporting on writes and reads
      t = '{id: 16'h0044, addr: 32'h1000, len: 8'd3, size: 3'd2, burst: 2'b01, errm: 16'h0004};
      push_write(t, 1'b0);
      send_aw(t, hs);
      wait_done();
      t = '{id: 16'h0045, addr: 32'h2000, len: 8'd1, size: 3'd2, burst: 2'b01, errm: 16'h0002};
      issue_read(t);
      send_ar(t, hs);
      wait_done();

      // reset while the first beat of an 8-beat read waits for its response
      mem_mode = 2;
      t = '{id: 16'h0077, addr: 32'h400, len: 8'd7, size: 3'd2, burst: 2'b01, errm: 16'h0};
      exp_mem.push_back('{addr: 32'h400, we: 1'b0, be: 4'h0, wdata: 32'h0, err: 1'b0});
      send_ar(t, hs);
      for (int n = 0; n < 100 && exp_mem.size() != 0; n++) step();
      check("rst_mid_granted", 64'(exp_mem.size()), 64'(0));
      rst = 1'b1;
      step();
      rst = 1'b0;
      model_prio = 1'b0;
      @(negedge clk);
      check("rst_mid_mem_req", 64'(mem_req_o), 64'(0));
      check("rst_mid_r_valid", 64'(r_valid_o), 64'(0));
      check("rst_mid_readies", 64'({ar_ready_o, aw_ready_o}), 64'(0));
      check("rst_mid_r_data", 64'(r_data_o), 64'(0));
      step();
      repeat (12) step();
      mem_mode = 1;

      // arbitration: collision after reset, then after a lone read
      do_reset();
      t  = '{id: 16'h0101, addr: 32'h3000, len: 8'd1, size: 3'd2, burst: 2'b01, errm: 16'h0};
      t2 = '{id: 16'h0202, addr: 32'h4000, len: 8'd1, size: 3'd2, burst: 2'b01, errm: 16'h0};
      collide(t, t2);
      wait_done();
      t = '{id: 16'h0303, addr: 32'h5000, len: 8'd0, size: 3'd1, burst: 2'b01, errm: 16'h0};
      issue_read(t);
      send_ar(t, hs);
      wait_done();
      t  = '{id: 16'h0404, addr: 32'h6000, len: 8'd2, size: 3'd0, burst: 2'b01, errm: 16'h0};
      t2 = '{id: 16'h0505, addr: 32'h7000, len: 8'd2, size: 3'd2, burst: 2'b10, errm: 16'h0};
      collide(t, t2);
      wait_done();

      // randomized traffic with random grants, latencies and ready
      mem_mode = 0;
      rready_mode = 0;
      bready_rand = 1'b1;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 4))
            0, 1: begin
               t = rand_txn();
               issue_read(t);
               send_ar(t, hs);
            end
            2, 3: begin
               t = rand_txn();
               push_write(t, 1'b0);
               send_aw(t, hs);
            end
            default: begin
               t = rand_txn();
               t2 = rand_txn();
               collide(t, t2);
            end
         endcase
         wait_done();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
